bram_fifo_ctrl: RTL and testbench

//  Upstream controller for the single-port 1-cycle-read BRAM: presents the RAM as a

---
 rtl/bram_fifo_pkg.sv | 18 +
 rtl/bram_fifo_ctrl_if.sv | 35 +++
 rtl/bram_fifo_obuf.sv | 56 +++++
 rtl/bram_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared constants and types for the BRAM-backed FIFO controller.
//   BF_DW / BF_AW     : default data / address widths
//   BF_DEPTH          : RAM words for the default address width
//   BF_FILL_W         : width of the fill count (RAM + in-flight read + 2-entry buffer)
//   turn_t            : arbiter token, which side wins the single RAM port under contention
package bram_fifo_pkg;

  localparam int BF_DW     = 16;
  localparam int BF_AW     = 10;
  localparam int BF_DEPTH  = 1 << BF_AW;
  localparam int BF_FILL_W = BF_AW + 2;

  typedef enum logic {
    TURN_RD = 1'b0,
    TURN_WR = 1'b1
  } turn_t;

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Stream and memory-port bundle for bram_fifo_ctrl.
//   s_data/s_valid/s_ready : write stream (producer -> FIFO)
//   m_data/m_valid/m_ready : read stream (FIFO -> consumer)
//   mem_din/mem_addr/mem_we: FIFO -> single-port BRAM
//   mem_dout               : BRAM -> FIFO, valid one cycle after a read issue
// Modport slave is the controller's view, master is the surrounding system's view.
interface bram_fifo_ctrl_if
  import bram_fifo_pkg::*;
#(
  parameter int DW = BF_DW,
  parameter int AW = BF_AW
);

  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] mem_din;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  s_data, s_valid, m_ready, mem_dout,
    output s_ready, m_data, m_valid, mem_din, mem_addr, mem_we
  );

  modport master (
    output s_data, s_valid, m_ready, mem_dout,
    input  s_ready, m_data, m_valid, mem_din, mem_addr, mem_we
  );

endinterface

// File: rtl/bram_fifo_obuf.sv
// Two-entry output skid buffer that absorbs the BRAM read latency.
//   clk, rst_n : clock, synchronous active-low reset (clears the count only)
//   push       : capture push_data at the tail this cycle
//   push_data  : word arriving from the BRAM
//   pop        : head consumed this cycle (caller only pops when cnt != 0)
//   head       : oldest word held
//   cnt        : words held, 0..2
// Push and pop in the same cycle are legal; the caller never pushes into a full buffer.
module bram_fifo_obuf
  import bram_fifo_pkg::*;
#(
  parameter int DW = BF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    cnt
);

  logic [DW-1:0] e0_p2;
  logic [DW-1:0] e1_p2;
  logic [1:0]    cnt_p2;

  // ---- stage p2: buffered read data ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p2 <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   cnt_p2 <= cnt_p2 + 2'd1;
        2'b01:   cnt_p2 <= cnt_p2 - 2'd1;
        default: cnt_p2 <= cnt_p2;
      endcase
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 forward, and a simultaneous
  // push lands in whichever slot becomes the tail after the shift.
  always_ff @(posedge clk) begin
    if (pop) begin
      if (push && (cnt_p2 == 2'd1)) e0_p2 <= push_data;
      else                          e0_p2 <= e1_p2;
      if (push && (cnt_p2 == 2'd2)) e1_p2 <= push_data;
    end else if (push) begin
      if (cnt_p2 == 2'd0) e0_p2 <= push_data;
      else                e1_p2 <= push_data;
    end
  end

  assign head = e0_p2;
  assign cnt  = cnt_p2;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// DEPTH x DW FIFO built on a single-port BRAM with 1-cycle read latency.
//   clk, rst_n : single clock, synchronous active-low reset
//   bus        : slave view of bram_fifo_ctrl_if (write stream, read stream, BRAM port)
//   fill       : words held in total (RAM + in-flight read + output buffer), 0..DEPTH+2
// One RAM access per cycle. A read is wanted whenever the RAM holds data and the
// output buffer (after this cycle's pop) plus the in-flight read leave a slot free.
// A one-bit turn token alternates reads and writes when both compete.
// Build option LOW_POWER_IDLE_EN: on idle cycles mem_addr/mem_din hold the last
// issued values instead of following rd_ptr/s_data, so the RAM pins do not toggle.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int DW = BF_DW,
  parameter int AW = BF_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  bram_fifo_ctrl_if.slave     bus,
  output logic [AW+1:0]       fill
);

  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_cnt;
  logic          rd_pend;
  turn_t         turn;
  turn_t         turn_nxt;

  logic [1:0]    obuf_cnt;
  logic [1:0]    obuf_left;
  logic          pop;
  logic          full;
  logic          read_wanted;
  logic          read_grant;
  logic          write_fire;

  // ---- stage p0: arbitration and RAM issue ----
  assign pop       = bus.m_valid && bus.m_ready;
  assign obuf_left = obuf_cnt - {1'b0, pop};
  assign full      = (ram_cnt == CNT_FULL);

  // obuf_left + rd_pend never exceeds 3, so the 2-bit sum cannot wrap.
  assign read_wanted = (ram_cnt != '0) && ((obuf_left + {1'b0, rd_pend}) < 2'd2);

  // Full can only be entered by a write, which hands the token to RD, so a full
  // RAM always sees turn==RD and cannot deadlock against a waiting producer.
  assign bus.s_ready = rst_n && !full && !(read_wanted && (turn == TURN_RD));
  assign write_fire  = bus.s_valid && bus.s_ready;
  assign read_grant  = read_wanted && ((turn == TURN_RD) || !bus.s_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) turn <= TURN_RD;
    else        turn <= turn_nxt;
  end

  always_comb begin
    turn_nxt = turn;
    if (write_fire)      turn_nxt = TURN_RD;
    else if (read_grant) turn_nxt = TURN_WR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (write_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (read_grant) rd_ptr <= rd_ptr + PTR_ONE;
      case ({write_fire, read_grant})
        2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
        2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
        default: ram_cnt <= ram_cnt;
      endcase
      rd_pend <= read_grant;
    end
  end

`ifdef LOW_POWER_IDLE_EN
  logic [AW-1:0] addr_hold;
  logic [DW-1:0] din_hold;

  always_ff @(posedge clk) begin
    if (write_fire || read_grant) begin
      addr_hold <= bus.mem_addr;
      din_hold  <= bus.mem_din;
    end
  end
`endif

  always_comb begin
    bus.mem_we = write_fire;
`ifdef LOW_POWER_IDLE_EN
    bus.mem_addr = addr_hold;
    bus.mem_din  = din_hold;
`else
    bus.mem_addr = rd_ptr;
    bus.mem_din  = bus.s_data;
`endif
    if (write_fire) begin
      bus.mem_addr = wr_ptr;
      bus.mem_din  = bus.s_data;
    end else if (read_grant) begin
      bus.mem_addr = rd_ptr;
    end
  end

  // ---- stage p1/p2: read data capture into the output buffer ----
  // rd_pend is cleared by reset, so a read issued just before reset is never captured.
  bram_fifo_obuf #(.DW(DW)) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend),
    .push_data (bus.mem_dout),
    .pop       (pop),
    .head      (bus.m_data),
    .cnt       (obuf_cnt)
  );

  assign bus.m_valid = (obuf_cnt != 2'd0);
  assign fill = {1'b0, ram_cnt} + {{(AW+1){1'b0}}, rd_pend} + {{AW{1'b0}}, obuf_cnt};

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
module tb_bram_fifo_ctrl;
  import bram_fifo_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int MAX_FILL = (1 << AW) + 2;

  logic          clk;
  logic          rst_n;
  logic [AW+1:0] fill;
  int            cyc;
  int            errors;
  int            checks;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  bram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  bram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .fill  (fill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port BRAM, 1-cycle read.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= mem[bus.mem_addr];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: accepted words are queued, emitted words must match in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("fill_model", int'(fill), exp_q.size());
      chk("fill_bound", (int'(fill) <= MAX_FILL) ? 1 : 0, 1);
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else                   chk("data_order", bus.m_data, exp_q.pop_front());
      end
      if (bus.s_valid && bus.s_ready) exp_q.push_back(bus.s_data);
    end
  end

  task automatic set_mready(input int mode);
    if (mode == 0)      bus.m_ready = 1'b1;
    else if (mode == 1) bus.m_ready = (cyc % 3 == 0);
    else                bus.m_ready = 1'b0;
  endtask

  // mode: 0 consumer always ready, 1 ready one cycle in three, 2 never ready
  task automatic run_stream(input int nwords, input int pv, input int mode,
                            input bit seq, input int max_cyc);
    int sent = 0;
    int n = 0;
    bit acc;
    set_mready(mode);
    bus.s_valid = ($urandom_range(0, 99) < pv);
    bus.s_data  = seq ? 16'(sent) : 16'($urandom);
    while (sent < nwords && n < max_cyc) begin
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      if (acc) sent++;
      @(posedge clk); #1;
      n++;
      set_mready(mode);
      if (acc || !bus.s_valid) begin
        bus.s_valid = (sent < nwords) && ($urandom_range(0, 99) < pv);
        bus.s_data  = seq ? 16'(sent) : 16'($urandom);
      end
    end
    bus.s_valid = 1'b0;
    chk("stream_words", sent, nwords);
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.m_valid) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_fill", int'(fill), 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int lat;
    bit prev_we;
    bit acc;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;

    errors = 0;
    checks = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_mem_we", bus.mem_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.m_ready = 1'b1;

    // Single word: first m_valid three cycles after the write
    @(posedge clk); #1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h1234;
    @(negedge clk);
    chk("t1_s_ready", bus.s_ready, 1);
    t0 = cyc;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        lat = cyc - t0;
        chk("t1_data", bus.m_data, 16'h1234);
      end
    end
    chk("t1_latency", lat, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_fill_zero", int'(fill), 0);
    @(posedge clk); #1;

    // Fill to capacity with the consumer stalled, then drain in order
    run_stream(MAX_FILL, 100, 2, 1'b1, 6000);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'(MAX_FILL);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_full_s_ready", bus.s_ready, 0);
      chk("t2_full_fill", int'(fill), MAX_FILL);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    drain(4000);
    @(posedge clk); #1;

    // Both sides always busy: RAM port strictly alternates write/read
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'($urandom);
    prev_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc = bus.s_ready;
      if (i >= 6) chk("t3_we_alt", bus.mem_we, !prev_we);
      prev_we = bus.mem_we;
      @(posedge clk); #1;
      if (acc) bus.s_data = 16'($urandom);
    end
    drain(100);
    @(posedge clk); #1;

    // Random producer, consumer ready one cycle in three
    run_stream(5000, 60, 1, 1'b0, 40000);
    drain(4000);
    @(posedge clk); #1;

    // Low-fill streaming long enough to wrap both pointers
    run_stream(3000, 50, 0, 1'b0, 20000);
    drain(100);
    @(posedge clk); #1;

    // Reset while a read is in flight and the buffer holds data
    run_stream(20, 100, 2, 1'b0, 500);
    repeat (4) @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.m_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_m_valid", bus.m_valid, 0);
    chk("t6_fill", int'(fill), 0);
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    a0 = bus.mem_addr;
    d0 = bus.mem_din;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.s_data = 16'($urandom);
      @(negedge clk);
      chk("t6_no_stale", bus.m_valid, 0);
`ifdef LOW_POWER_IDLE_EN
      chk("t6_idle_addr_hold", bus.mem_addr, a0);
      chk("t6_idle_din_hold", bus.mem_din, d0);
`else
      chk("t6_idle_addr", bus.mem_addr, 0);
      chk("t6_idle_din", bus.mem_din, bus.s_data);
`endif
    end
    @(posedge clk); #1;
    run_stream(50, 70, 0, 1'b0, 1000);
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
